// File: rtl/shift_register_pkg.sv
// Shared definitions for the serial shift-chain blocks: FSM encoding,
// counter width helper and the legal word-length range.
package shift_register_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_e;

   localparam int WIDTH_MIN = 2;
   localparam int WIDTH_MAX = 32;

   function automatic int cnt_w(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/shift_bit_counter.sv
// Modulo-WIDTH bit counter with synchronous clear, enable and a last-bit
// flag; shared by the PISO transmitter and the SIPO receiver.
module shift_bit_counter
   import shift_register_pkg::*;
#(
   parameter  int WIDTH = 8,
   localparam int CW    = cnt_w(WIDTH)
) (
   input  logic          Clk,
   input  logic          Rst_n,
   input  logic          clr,
   input  logic          en,
   output logic [CW-1:0] cnt,
   output logic          last
);

   localparam logic [CW-1:0] LAST_VAL = CW'(WIDTH - 1);

   assign last = (cnt == LAST_VAL);

   // clear wins over enable so a reload on the last bit restarts at 0
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (en)
         cnt <= last ? '0 : cnt + CW'(1);
   end

endmodule

// File: rtl/shift_register_piso_tx.sv
// Parallel-in serial-out transmitter: valid/ready word load, one bit per
// clock on Out with Out_valid and Frame_start markers, gapless back-to-back.
module shift_register_piso_tx
   import shift_register_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic [WIDTH-1:0] Din,
   input  logic             Load_valid,
   output logic             Load_ready,
   output logic             Out,
   output logic             Out_valid,
   output logic             Frame_start,
   output logic             Busy
);

   localparam int CW = cnt_w(WIDTH);

   if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
      $error("shift_register_piso_tx: WIDTH %0d outside %0d..%0d",
             WIDTH, WIDTH_MIN, WIDTH_MAX);
   end

   state_e           state;
   logic [WIDTH-1:0] sreg;
   logic [WIDTH-1:0] sreg_shifted;
   logic [CW-1:0]    cnt;
   logic             last;
   logic             in_shift;
   logic             hs;
   logic             cnt_clr;
   logic             cnt_en;

   assign in_shift   = (state == SHIFT);
   assign Load_ready = !in_shift || last;
   assign hs         = Load_valid && Load_ready;

   // counter restarts on every load and on the way back to IDLE
   assign cnt_clr = hs || (in_shift && last);
   assign cnt_en  = in_shift && !last;

   shift_bit_counter #(
      .WIDTH (WIDTH)
   ) u_cnt (
      .Clk   (Clk),
      .Rst_n (Rst_n),
      .clr   (cnt_clr),
      .en    (cnt_en),
      .cnt   (cnt),
      .last  (last)
   );

   if (MSB_FIRST) begin : g_msb
      assign sreg_shifted = {sreg[WIDTH-2:0], 1'b0};
      assign Out          = sreg[WIDTH-1];
   end else begin : g_lsb
      assign sreg_shifted = {1'b0, sreg[WIDTH-1:1]};
      assign Out          = sreg[0];
   end

   // the register is zeroed on entry to IDLE so Out reads 0 straight from it
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state <= IDLE;
         sreg  <= '0;
      end else if (hs) begin
         state <= SHIFT;
         sreg  <= Din;
      end else if (in_shift) begin
         if (last) begin
            state <= IDLE;
            sreg  <= '0;
         end else begin
            sreg  <= sreg_shifted;
         end
      end
   end

   assign Out_valid   = in_shift;
   assign Busy        = in_shift;
   assign Frame_start = in_shift && (cnt == '0);

endmodule

// File: tb/tb_shift_register_piso_tx.sv
// Checks MSB-first and LSB-first transmitters side by side against a
// queue-of-expected-bits model of the serial stream.
module tb_shift_register_piso_tx;

   logic       Clk = 1'b0;
   logic       Rst_n;
   logic [7:0] Din;
   logic       Load_valid;
   logic       rdy_m, out_m, ov_m, fs_m, busy_m;
   logic       rdy_l, out_l, ov_l, fs_l, busy_l;

   int nchk  = 0;
   int nfail = 0;

   bit qm[$];
   bit ql[$];
   bit qf[$];

   always #5 Clk = ~Clk;

   shift_register_piso_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
      .Clk(Clk), .Rst_n(Rst_n), .Din(Din), .Load_valid(Load_valid),
      .Load_ready(rdy_m), .Out(out_m), .Out_valid(ov_m),
      .Frame_start(fs_m), .Busy(busy_m));

   shift_register_piso_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
      .Clk(Clk), .Rst_n(Rst_n), .Din(Din), .Load_valid(Load_valid),
      .Load_ready(rdy_l), .Out(out_l), .Out_valid(ov_l),
      .Frame_start(fs_l), .Busy(busy_l));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // a new word can enter when at most the final bit of the current one remains
   function automatic bit model_ready();
      return qm.size() <= 1;
   endfunction

   task automatic check_ready(input string tag);
      chk({tag, ".rdy_m"}, rdy_m, model_ready());
      chk({tag, ".rdy_l"}, rdy_l, model_ready());
   endtask

   task automatic check_out(input string tag);
      bit v, em, el, ef;
      v  = qm.size() > 0;
      em = v ? qm[0] : 1'b0;
      el = v ? ql[0] : 1'b0;
      ef = v ? qf[0] : 1'b0;
      chk({tag, ".out_m"}, out_m, em);
      chk({tag, ".out_l"}, out_l, el);
      chk({tag, ".ov_m"}, ov_m, v);
      chk({tag, ".ov_l"}, ov_l, v);
      chk({tag, ".busy_m"}, busy_m, v);
      chk({tag, ".busy_l"}, busy_l, v);
      chk({tag, ".fs_m"}, fs_m, ef);
      chk({tag, ".fs_l"}, fs_l, ef);
   endtask

   // one clock: present inputs, check ready, clock, advance model, check outputs
   task automatic cycle(input string tag, input logic v, input logic [7:0] d, output bit hs);
      Load_valid = v;
      Din        = d;
      #1;
      check_ready(tag);
      hs = v && model_ready();
      @(posedge Clk);
      if (qm.size() > 0) begin
         void'(qm.pop_front());
         void'(ql.pop_front());
         void'(qf.pop_front());
      end
      if (hs) begin
         for (int k = 0; k < 8; k++) begin
            qm.push_back(d[7-k]);
            ql.push_back(d[k]);
            qf.push_back(k == 0);
         end
      end
      @(negedge Clk);
      check_out(tag);
   endtask

   // holds Load_valid until accepted; returns how many cycles it took
   task automatic send_hold(input string tag, input logic [7:0] d, output int n);
      bit hs;
      n = 0;
      do begin
         cycle(tag, 1'b1, d, hs);
         n++;
      end while (!hs && n < 40);
      chk({tag, ".accepted"}, hs, 1'b1);
   endtask

   task automatic idle(input string tag, input int n);
      bit hs;
      for (int i = 0; i < n; i++) cycle(tag, 1'b0, $urandom, hs);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      bit hs;
      Rst_n      = 1'b0;
      Load_valid = 1'b1;
      Din        = 8'h55;
      @(negedge Clk);
      @(negedge Clk);
      // reset state, with a valid offer that must not be taken
      check_out("reset");
      check_ready("reset");
      #1 Rst_n = 1'b1;
      Load_valid = 1'b0;
      idle("idle", 2);

      send_hold("a5_word", 8'hA5, n);
      idle("a5_drain", 9);
      send_hold("0f_word", 8'h0F, n);
      idle("0f_drain", 9);

      // back-to-back: second word held from the first handshake onward
      cycle("b2b_first", 1'b1, 8'hA5, hs);
      chk("b2b_first.hs", hs, 1'b1);
      send_hold("b2b_second", 8'h3C, n);
      chk("b2b_second_edge", n, 8);
      idle("b2b_drain", 9);

      // offer during bit 3 of an in-flight word
      send_hold("busy_word", 8'hA5, n);
      idle("busy_bits", 3);
      send_hold("busy_ff", 8'hFF, n);
      chk("busy_ff_wait", n, 5);
      idle("busy_drain", 9);

      // random traffic
      for (int i = 0; i < 300; i++)
         cycle("rand", ($urandom_range(3, 0) != 0), $urandom, hs);
      idle("rand_drain", 9);

      // asynchronous reset during bit 4
      send_hold("rst_word", $urandom, n);
      idle("rst_bits", 4);
      #2 Rst_n = 1'b0;
      #1;
      qm.delete();
      ql.delete();
      qf.delete();
      check_out("rst_async");
      Load_valid = 1'b1;
      Din        = 8'h55;
      #1;
      check_ready("rst_low");
      @(posedge Clk);
      @(negedge Clk);
      check_out("rst_hold");
      #1 Rst_n = 1'b1;
      Load_valid = 1'b0;
      send_hold("post_rst_81", 8'h81, n);
      chk("post_rst_81_wait", n, 1);
      idle("post_rst_drain", 10);

      $display("%0d/%0d checks passed", nchk - nfail, nchk);
      $finish;
   end

endmodule
